// File: rtl/level_builder_pkg.sv
// Shared memory-game definitions: note encoding, level FSM states and the LFSR mask.
// The audio block reuses LFSR_MASK, so keep it here rather than in lfsr16.
package level_builder_pkg;

  localparam int          NOTE_W    = 4;
  localparam logic [3:0]  NOTE_0    = 4'b0001;
  localparam logic [3:0]  NOTE_1    = 4'b0010;
  localparam logic [3:0]  NOTE_2    = 4'b0100;
  localparam logic [3:0]  NOTE_3    = 4'b1000;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GEN      = 2'd1,
    READY    = 2'd2,
    COMPLETE = 2'd3
  } state_t;

  function automatic logic [3:0] note_decode(input logic [1:0] sel);
    logic [3:0] n;
    case (sel)
      2'd0:    n = NOTE_0;
      2'd1:    n = NOTE_1;
      2'd2:    n = NOTE_2;
      2'd3:    n = NOTE_3;
      default: n = NOTE_0;
    endcase
    return n;
  endfunction

  function automatic logic [3:0] rotl_note(input logic [3:0] n);
    return {n[2:0], n[3]};
  endfunction

endpackage

// File: rtl/level_builder_if.sv
// Level hand-off between level_builder (slave) and the game core (master).
interface level_builder_if #(
  parameter int MAX_NOTES = 4
);
  logic                   new_game;
  logic                   next_level;
  logic [4*MAX_NOTES-1:0] level_data;
  logic [3:0]             level_length;
  logic                   level_ready;
  logic                   game_complete;

  modport master (
    output new_game, next_level,
    input  level_data, level_length, level_ready, game_complete
  );

  modport slave (
    input  new_game, next_level,
    output level_data, level_length, level_ready, game_complete
  );
endinterface

// File: rtl/level_builder_lfsr16.sv
// Free-running 16-bit Galois LFSR (right shift); a zero seed is forced to 1
// so the register can never lock up in the all-zero state.
module lfsr16
  import level_builder_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] r_lfsr;

  // Shift every cycle, folding the mask in whenever a 1 drops out of bit 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_lfsr <= SEED_EFF;
    else       r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_MASK : 16'h0000);
  end

  assign q = r_lfsr;
endmodule

// File: rtl/level_builder.sv
// Builds the growing one-hot note sequence for each round of the memory game.
// One note is appended per GEN cycle; stored nibbles only change on new_game.
module level_builder
  import level_builder_pkg::*;
#(
  parameter int          MAX_NOTES   = 4,
  parameter int          START_NOTES = 1,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic           clk,
  input  logic           reset,
  level_builder_if.slave bus
);
  localparam int         DATA_W    = NOTE_W * MAX_NOTES;
  localparam logic [3:0] MAX_LEN   = 4'(MAX_NOTES);
  localparam logic [3:0] START_LEN = 4'(START_NOTES);

  state_t            r_state;
  logic [DATA_W-1:0] r_data;
  logic [3:0]        r_length;
  logic [3:0]        r_target;
  logic              r_ready;
  logic              r_complete;

  logic [15:0]       w_lfsr;
  logic              w_unused_lfsr;
  logic [3:0]        w_draw;
  logic [3:0]        w_note;
  logic [3:0]        w_length_inc;
  logic [3:0]        w_prev_chain [MAX_NOTES+1];
  logic [DATA_W-1:0] w_data_app;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (w_lfsr)
  );

  assign w_unused_lfsr   = ^w_lfsr[15:2];
  assign w_length_inc    = r_length + 4'd1;
  assign w_prev_chain[0] = 4'd0;

  // Per nibble: OR-select the last stored note, and build the appended vector
  for (genvar g = 0; g < MAX_NOTES; g++) begin : g_nib
    localparam logic [3:0] IDX = 4'(g);
    assign w_prev_chain[g+1] = w_prev_chain[g] |
      (r_data[DATA_W-1-NOTE_W*g -: NOTE_W] & {NOTE_W{(IDX + 4'd1) == r_length}});
    assign w_data_app[DATA_W-1-NOTE_W*g -: NOTE_W] =
      (IDX == r_length) ? w_note : r_data[DATA_W-1-NOTE_W*g -: NOTE_W];
  end

  // Draw a note and nudge it one position if it would repeat the previous one
  always_comb begin
    w_draw = note_decode(w_lfsr[1:0]);
    if ((r_length != 4'd0) && (w_draw == w_prev_chain[MAX_NOTES])) w_note = rotl_note(w_draw);
    else                                                          w_note = w_draw;
  end

  // Level FSM; new_game overrides everything, including a pending next_level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_data     <= '0;
      r_length   <= 4'd0;
      r_target   <= 4'd0;
      r_ready    <= 1'b0;
      r_complete <= 1'b0;
    end else if (bus.new_game) begin
      r_state    <= GEN;
      r_data     <= '0;
      r_length   <= 4'd0;
      r_target   <= START_LEN;
      r_ready    <= 1'b0;
      r_complete <= 1'b0;
    end else begin
      case (r_state)
        IDLE: r_state <= IDLE;
        GEN: begin
          r_data   <= w_data_app;
          r_length <= w_length_inc;
          if (w_length_inc == r_target) begin
            r_state <= READY;
            r_ready <= 1'b1;
          end else begin
            r_state <= GEN;
          end
        end
        READY: begin
          if (bus.next_level) begin
            r_ready <= 1'b0;
            if (r_length == MAX_LEN) begin
              r_state    <= COMPLETE;
              r_complete <= 1'b1;
            end else begin
              r_target <= w_length_inc;
              r_state  <= GEN;
            end
          end else begin
            r_state <= READY;
          end
        end
        COMPLETE: r_state <= COMPLETE;
        default: begin
          r_state    <= IDLE;
          r_ready    <= 1'b0;
          r_complete <= 1'b0;
        end
      endcase
    end
  end

  assign bus.level_data    = r_data;
  assign bus.level_length  = r_length;
  assign bus.level_ready   = r_ready;
  assign bus.game_complete = r_complete;
endmodule

// File: tb/tb_level_builder.sv
// Self-checking bench for level_builder: four instances with different parameters
// checked against a note-index model driven by a reference LFSR history.
module tb_level_builder;
  import level_builder_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [15:0] m_lfsr;
  logic [15:0] m_lfsr_z;
  logic [15:0] hist [0:65535];
  int exp_a[$];
  int exp_b[$];
  int exp_c[$];

  level_builder_if #(.MAX_NOTES(4))  bus_a ();
  level_builder_if #(.MAX_NOTES(4))  bus_b ();
  level_builder_if #(.MAX_NOTES(15)) bus_c ();
  level_builder_if #(.MAX_NOTES(4))  bus_z ();

  level_builder dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  level_builder #(.MAX_NOTES(4), .START_NOTES(3)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));
  level_builder #(.MAX_NOTES(15)) dut_c (.clk(clk), .reset(reset), .bus(bus_c));
  level_builder #(.LFSR_SEED(16'h0000)) dut_z (.clk(clk), .reset(reset), .bus(bus_z));

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Reference LFSRs; hist[k] is the value the DUT sees just before edge k
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_lfsr   <= 16'hACE1;
      m_lfsr_z <= 16'h0001;
    end else begin
      hist[16'(cyc)] <= m_lfsr;
      m_lfsr         <= lfsr_next(m_lfsr);
      m_lfsr_z       <= lfsr_next(m_lfsr_z);
      cyc            <= cyc + 1;
    end
  end

  function automatic logic [15:0] h(input int k);
    return hist[16'(k)];
  endfunction

  // Next note index: lfsr mod 4, bumped by one if it equals the previous note
  function automatic int next_note(input int q[$], input logic [15:0] v);
    int n;
    n = int'(v % 16'd4);
    if (q.size() > 0 && n == q[q.size()-1]) n = (n + 1) % 4;
    return n;
  endfunction

  function automatic logic [63:0] pack(input int q[$], input int maxn);
    logic [63:0] r;
    r = 64'd0;
    foreach (q[i]) r = r | ((64'd1 << q[i]) << (4 * (maxn - 1 - i)));
    return r;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus_a.new_game = 1'b0; bus_a.next_level = 1'b0;
    bus_b.new_game = 1'b0; bus_b.next_level = 1'b0;
    bus_c.new_game = 1'b0; bus_c.next_level = 1'b0;
    bus_z.new_game = 1'b0; bus_z.next_level = 1'b0;
    reset = 1'b1;
    step; step;
    reset = 1'b0;
    step;
    bus_b.new_game = 1'b1;
    step;
    bus_b.new_game = 1'b0;
    step;
    n_cmp++;
    if (dut_b.r_state !== GEN || bus_b.level_length !== 4'd1) begin
      n_bad++;
      $display("FAIL reset_pre_gen: state=%0d len=%0d, required GEN(1) len=1", dut_b.r_state, bus_b.level_length);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus_b.level_data, bus_b.level_length, bus_b.level_ready, bus_b.game_complete} !== 22'd0) begin
      n_bad++;
      $display("FAIL reset_outputs_b: data=%h len=%0d rdy=%b cmp=%b, required all 0",
               bus_b.level_data, bus_b.level_length, bus_b.level_ready, bus_b.game_complete);
    end
    n_cmp++;
    if (dut_b.u_lfsr.q !== 16'hACE1) begin
      n_bad++;
      $display("FAIL reset_lfsr: got %h, required ace1", dut_b.u_lfsr.q);
    end
    n_cmp++;
    if (dut_b.r_state !== IDLE) begin
      n_bad++;
      $display("FAIL reset_state: got %0d, required IDLE(0)", dut_b.r_state);
    end
    n_cmp++;
    if ({bus_a.level_data, bus_a.level_length, bus_a.level_ready, bus_a.game_complete} !== 22'd0) begin
      n_bad++;
      $display("FAIL reset_outputs_a: data=%h len=%0d, required all 0", bus_a.level_data, bus_a.level_length);
    end
    n_cmp++;
    if (dut_z.u_lfsr.q !== 16'h0001) begin
      n_bad++;
      $display("FAIL zero_seed_reset: got %h, required 0001", dut_z.u_lfsr.q);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_new_game;
    int cn;
    logic [63:0] e;
    step;
    cn = cyc;
    bus_a.new_game = 1'b1;
    step;
    bus_a.new_game = 1'b0;
    n_cmp++;
    if (bus_a.level_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL new_game_gen: ready=%b, required 0", bus_a.level_ready);
    end
    step;
    exp_a.delete();
    exp_a.push_back(next_note(exp_a, h(cn + 1)));
    e = pack(exp_a, 4);
    n_cmp++;
    if (bus_a.level_ready !== 1'b1 || bus_a.level_length !== 4'd1) begin
      n_bad++;
      $display("FAIL new_game_ready: ready=%b len=%0d, required 1 / 1", bus_a.level_ready, bus_a.level_length);
    end
    n_cmp++;
    if ($countones(bus_a.level_data[15:12]) != 1 || bus_a.level_data[11:0] !== 12'd0) begin
      n_bad++;
      $display("FAIL new_game_onehot: data=%h, required one-hot MS nibble, rest 0", bus_a.level_data);
    end
    n_cmp++;
    if (bus_a.level_data !== e[15:0]) begin
      n_bad++;
      $display("FAIL new_game_data: got %h, required %h", bus_a.level_data, e[15:0]);
    end
  endtask

  task automatic test_full_game;
    for (int lvl = 2; lvl <= 5; lvl++) begin
      int cn;
      logic [15:0] held;
      logic [63:0] e;
      held = bus_a.level_data;
      repeat ($urandom_range(0, 3)) step;
      n_cmp++;
      if (bus_a.level_data !== held || bus_a.level_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL hold_ready: data=%h rdy=%b, required %h / 1", bus_a.level_data, bus_a.level_ready, held);
      end
      cn = cyc;
      bus_a.next_level = 1'b1;
      step;
      bus_a.next_level = 1'b0;
      if (lvl <= 4) begin
        n_cmp++;
        if (bus_a.level_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL level_drop: lvl=%0d ready=%b, required 0", lvl, bus_a.level_ready);
        end
        step;
        exp_a.push_back(next_note(exp_a, h(cn + 1)));
        e = pack(exp_a, 4);
        n_cmp++;
        if (bus_a.level_ready !== 1'b1 || bus_a.level_length !== 4'(lvl) || bus_a.level_data !== e[15:0]) begin
          n_bad++;
          $display("FAIL level_up: lvl=%0d rdy=%b len=%0d data=%h, required 1 / %0d / %h",
                   lvl, bus_a.level_ready, bus_a.level_length, bus_a.level_data, lvl, e[15:0]);
        end
      end else begin
        n_cmp++;
        if (bus_a.game_complete !== 1'b1 || bus_a.level_ready !== 1'b0 || bus_a.level_data !== held) begin
          n_bad++;
          $display("FAIL game_complete: cmp=%b rdy=%b data=%h, required 1 / 0 / %h",
                   bus_a.game_complete, bus_a.level_ready, bus_a.level_data, held);
        end
      end
    end
  endtask

  task automatic test_illegal_pulses;
    int cn;
    logic [63:0] e;
    bus_a.next_level = 1'b1;
    step;
    bus_a.next_level = 1'b0;
    step;
    n_cmp++;
    if (bus_a.game_complete !== 1'b1 || bus_a.level_ready !== 1'b0 || bus_a.level_length !== 4'd4) begin
      n_bad++;
      $display("FAIL next_in_complete: cmp=%b rdy=%b len=%0d, required 1 / 0 / 4",
               bus_a.game_complete, bus_a.level_ready, bus_a.level_length);
    end
    cn = cyc;
    bus_a.new_game = 1'b1;
    step;
    bus_a.new_game = 1'b0;
    n_cmp++;
    if (bus_a.game_complete !== 1'b0 || bus_a.level_length !== 4'd0) begin
      n_bad++;
      $display("FAIL new_from_complete: cmp=%b len=%0d, required 0 / 0", bus_a.game_complete, bus_a.level_length);
    end
    step;
    exp_a.delete();
    exp_a.push_back(next_note(exp_a, h(cn + 1)));
    e = pack(exp_a, 4);
    n_cmp++;
    if (bus_a.level_ready !== 1'b1 || bus_a.level_data !== e[15:0]) begin
      n_bad++;
      $display("FAIL restart_data: rdy=%b data=%h, required 1 / %h", bus_a.level_ready, bus_a.level_data, e[15:0]);
    end
    // next_level during GEN on the START_NOTES=3 instance
    cn = cyc;
    bus_b.new_game = 1'b1;
    step;
    bus_b.new_game   = 1'b0;
    bus_b.next_level = 1'b1;
    step;
    bus_b.next_level = 1'b0;
    step; step;
    exp_b.delete();
    for (int k = 1; k <= 3; k++) exp_b.push_back(next_note(exp_b, h(cn + k)));
    e = pack(exp_b, 4);
    n_cmp++;
    if (bus_b.level_ready !== 1'b1 || bus_b.level_length !== 4'd3 || bus_b.level_data !== e[15:0]) begin
      n_bad++;
      $display("FAIL next_in_gen: rdy=%b len=%0d data=%h, required 1 / 3 / %h",
               bus_b.level_ready, bus_b.level_length, bus_b.level_data, e[15:0]);
    end
    step; step;
    n_cmp++;
    if (bus_b.level_ready !== 1'b1 || bus_b.level_length !== 4'd3) begin
      n_bad++;
      $display("FAIL next_not_queued: rdy=%b len=%0d, required 1 / 3", bus_b.level_ready, bus_b.level_length);
    end
    cn = cyc;
    bus_b.new_game   = 1'b1;
    bus_b.next_level = 1'b1;
    step;
    bus_b.new_game   = 1'b0;
    bus_b.next_level = 1'b0;
    n_cmp++;
    if (bus_b.level_length !== 4'd0 || bus_b.level_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL simul_clear: len=%0d rdy=%b, required 0 / 0", bus_b.level_length, bus_b.level_ready);
    end
    step; step; step;
    exp_b.delete();
    for (int k = 1; k <= 3; k++) exp_b.push_back(next_note(exp_b, h(cn + k)));
    e = pack(exp_b, 4);
    n_cmp++;
    if (bus_b.level_ready !== 1'b1 || bus_b.level_length !== 4'd3 || bus_b.level_data !== e[15:0]) begin
      n_bad++;
      $display("FAIL simul_pulses: rdy=%b len=%0d data=%h, required 1 / 3 / %h",
               bus_b.level_ready, bus_b.level_length, bus_b.level_data, e[15:0]);
    end
  endtask

  task automatic test_restart_mid_gen;
    int cn;
    logic [63:0] e;
    bus_b.new_game = 1'b1;
    step;
    bus_b.new_game = 1'b0;
    step;
    cn = cyc;
    bus_b.new_game = 1'b1;
    step;
    bus_b.new_game = 1'b0;
    n_cmp++;
    if (bus_b.level_length !== 4'd0 || bus_b.level_data !== 16'd0) begin
      n_bad++;
      $display("FAIL restart_clear: len=%0d data=%h, required 0 / 0000", bus_b.level_length, bus_b.level_data);
    end
    step; step; step;
    exp_b.delete();
    for (int k = 1; k <= 3; k++) exp_b.push_back(next_note(exp_b, h(cn + k)));
    e = pack(exp_b, 4);
    n_cmp++;
    if (bus_b.level_ready !== 1'b1 || bus_b.level_length !== 4'd3 || bus_b.level_data !== e[15:0]) begin
      n_bad++;
      $display("FAIL restart_mid_gen: rdy=%b len=%0d data=%h, required 1 / 3 / %h",
               bus_b.level_ready, bus_b.level_length, bus_b.level_data, e[15:0]);
    end
  endtask

  task automatic test_zero_seed;
    int bad_cycles;
    bad_cycles = 0;
    repeat (300) begin
      step;
      if (dut_z.u_lfsr.q == 16'h0000 || dut_z.u_lfsr.q !== m_lfsr_z) bad_cycles++;
    end
    n_cmp++;
    if (bad_cycles != 0) begin
      n_bad++;
      $display("FAIL zero_seed_run: %0d bad cycles (last q=%h model=%h), required 0",
               bad_cycles, dut_z.u_lfsr.q, m_lfsr_z);
    end
  endtask

  task automatic test_no_repeat;
    for (int g = 0; g < 1000; g++) begin
      int cn;
      int bad;
      logic [3:0] nib;
      logic [3:0] pn;
      logic [63:0] e;
      repeat ($urandom_range(0, 3)) step;
      exp_c.delete();
      cn = cyc;
      bus_c.new_game = 1'b1;
      step;
      bus_c.new_game = 1'b0;
      step;
      exp_c.push_back(next_note(exp_c, h(cn + 1)));
      for (int lvl = 2; lvl <= 15; lvl++) begin
        cn = cyc;
        bus_c.next_level = 1'b1;
        step;
        bus_c.next_level = 1'b0;
        step;
        exp_c.push_back(next_note(exp_c, h(cn + 1)));
      end
      bad = 0;
      pn  = 4'd0;
      for (int i = 0; i < 15; i++) begin
        nib = 4'(bus_c.level_data >> (4 * (14 - i)));
        if ($countones(nib) != 1) bad++;
        if (i > 0 && nib == pn) bad++;
        pn = nib;
      end
      n_cmp++;
      if (bad != 0) begin
        n_bad++;
        $display("FAIL no_repeat: game %0d data=%h has %0d rule violations", g, bus_c.level_data, bad);
      end
      e = pack(exp_c, 15);
      n_cmp++;
      if (bus_c.level_length !== 4'd15 || bus_c.level_data !== e[59:0]) begin
        n_bad++;
        $display("FAIL long_game: game %0d len=%0d data=%h, required 15 / %h",
                 g, bus_c.level_length, bus_c.level_data, e[59:0]);
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_new_game;
    test_full_game;
    test_illegal_pulses;
    test_restart_mid_gen;
    test_zero_seed;
    test_no_repeat;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
